// File: rtl/cpu_state_streamer.sv
// Debug snapshot streamer: on trigger, stalls the CPU and emits one valid/ready frame
// made of a header beat, the captured PC and every architectural register in order.
module cpu_state_streamer #(
    parameter int unsigned NUM_REGS = 32,
    parameter logic [7:0]  MAGIC    = 8'hA5,
    parameter int unsigned SEQ_W    = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        enable_i,
    input  logic        trigger_i,
    input  logic [31:0] pc_i,
    output logic [4:0]  rf_addr_o,
    input  logic [31:0] rf_data_i,
    output logic        stall_o,
    output logic [31:0] data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        busy_o,
    output logic [7:0]  drop_cnt_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PCB  = 2'd2,
        REGS = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [SEQ_W-1:0]    seq_q, seq_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [ADDR_W-1:0]   rf_addr_q, rf_addr_d;
    logic                valid_q, valid_d;
    logic                last_q, last_d;
    logic                busy_q, busy_d;
    logic                stall_q, stall_d;
    logic [CNT_W-1:0]    drop_q, drop_d;

    logic                hs;
    logic                start;
    logic [IDX_W-1:0]    idx_nxt;

    assign hs      = valid_q & ready_i;
    assign start   = trigger_i & enable_i;
    assign idx_nxt = idx_q + IDX_W'(1);

    // Next-state and datapath loads
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        idx_d     = idx_q;
        pc_d      = pc_q;
        data_d    = data_q;
        rf_addr_d = rf_addr_q;
        valid_d   = valid_q;
        last_d    = last_q;
        busy_d    = busy_q;
        stall_d   = stall_q;
        drop_d    = drop_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = HDR;
                    pc_d      = pc_i;
                    data_d    = {MAGIC, 24'(seq_q)};
                    valid_d   = 1'b1;
                    busy_d    = 1'b1;
                    stall_d   = 1'b1;
                    last_d    = 1'b0;
                    idx_d     = '0;
                    rf_addr_d = '0;
                end
            end
            HDR: begin
                if (hs) begin
                    state_d = PCB;
                    data_d  = pc_q;
                end
            end
            PCB: begin
                if (hs) begin
                    state_d   = REGS;
                    data_d    = rf_data_i;
                    idx_d     = IDX_W'(1);
                    last_d    = (NUM_REGS == 1);
                    rf_addr_d = (NUM_REGS > 1) ? ADDR_W'(1) : '0;
                end
            end
            REGS: begin
                if (hs) begin
                    if (idx_q < IDX_W'(NUM_REGS)) begin
                        data_d    = rf_data_i;
                        idx_d     = idx_nxt;
                        last_d    = (idx_q == IDX_W'(NUM_REGS - 1));
                        rf_addr_d = (idx_nxt < IDX_W'(NUM_REGS)) ? idx_nxt[ADDR_W-1:0] : '0;
                    end else begin
                        // Last beat accepted: release the CPU and close the frame
                        state_d   = IDLE;
                        valid_d   = 1'b0;
                        last_d    = 1'b0;
                        busy_d    = 1'b0;
                        stall_d   = 1'b0;
                        idx_d     = '0;
                        rf_addr_d = '0;
                        seq_d     = seq_q + SEQ_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Any request that cannot start a frame this cycle is a drop
        if (start && (state_q != IDLE) && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= IDLE;
            seq_q     <= '0;
            idx_q     <= '0;
            pc_q      <= '0;
            data_q    <= '0;
            rf_addr_q <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            stall_q   <= 1'b0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            seq_q     <= seq_d;
            idx_q     <= idx_d;
            pc_q      <= pc_d;
            data_q    <= data_d;
            rf_addr_q <= rf_addr_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            stall_q   <= stall_d;
            drop_q    <= drop_d;
        end
    end

    assign rf_addr_o  = rf_addr_q;
    assign stall_o    = stall_q;
    assign data_o     = data_q;
    assign valid_o    = valid_q;
    assign last_o     = last_q;
    assign busy_o     = busy_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_cpu_state_streamer.sv
// Scoreboard bench for cpu_state_streamer: frames are predicted at trigger time and
// compared beat by beat as the sink accepts them.
module tb_cpu_state_streamer;

    localparam int unsigned NREGS = 32;
    localparam int unsigned SEQW  = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        enable_i;
    logic        trigger_i;
    logic [31:0] pc_i;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_i;
    logic        stall_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        last_o;
    logic        busy_o;
    logic [7:0]  drop_cnt_o;

    cpu_state_streamer #(
        .NUM_REGS (NREGS),
        .MAGIC    (8'hA5),
        .SEQ_W    (SEQW)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .enable_i   (enable_i),
        .trigger_i  (trigger_i),
        .pc_i       (pc_i),
        .rf_addr_o  (rf_addr_o),
        .rf_data_i  (rf_data_i),
        .stall_o    (stall_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i),
        .last_o     (last_o),
        .busy_o     (busy_o),
        .drop_cnt_o (drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    logic [31:0] rf [NREGS];
    assign rf_data_i = rf[rf_addr_o];

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          exp_seq = 0;
    int          checks  = 0;
    int          errors  = 0;
    int          beats   = 0;
    logic        hold    = 1'b0;
    logic [31:0] hold_data = '0;
    logic        pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] pc);
        beat_t b;
        b.data = 32'hA500_0000 | 32'(exp_seq);
        b.last = 1'b0;
        exp_q.push_back(b);
        b.data = pc;
        exp_q.push_back(b);
        for (int k = 0; k < int'(NREGS); k++) begin
            b.data = rf[k];
            b.last = (k == int'(NREGS) - 1);
            exp_q.push_back(b);
        end
        exp_seq = (exp_seq + 1) % (1 << SEQW);
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk_i);
            if (!busy_o) break;
            @(posedge clk_i);
            #1;
        end
        check_eq(tag, 32'(busy_o), 32'd0);
    endtask

    // mode 0: ready held high; mode 1: ready follows the 1,0,0,1 pattern
    task automatic run_frame(input int mode, input logic [31:0] pc);
        int stalls;
        stalls    = 0;
        pc_i      = pc;
        trigger_i = 1'b1;
        push_frame(pc);
        tick();
        trigger_i = 1'b0;
        pc_i      = 32'hDEAD_BEEF;
        for (int c = 0; c < 400; c++) begin
            ready_i = (mode == 0) ? 1'b1 : pat[c % 4];
            @(negedge clk_i);
            if (!busy_o) break;
            if (stall_o) stalls++;
            @(posedge clk_i);
            #1;
        end
        check_eq("frame_done", 32'(busy_o), 32'd0);
        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("idle_stall", 32'(stall_o), 32'd0);
        if (mode == 0) check_eq("stall_cycles", 32'(stalls), 32'(NREGS + 2));
    endtask

    // Sink-side monitor: compares accepted beats and checks hold stability
    always @(negedge clk_i) begin
        beat_t e;
        if (!rst_i) begin
            hold  = 1'b0;
            beats = 0;
        end else begin
            if (hold) begin
                check_eq("hold_valid", 32'(valid_o), 32'd1);
                check_eq("hold_data", data_o, hold_data);
            end
            if (valid_o && ready_i) begin
                if (exp_q.size() == 0) begin
                    check_eq("beat_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    beats++;
                    check_eq("beat_data", data_o, e.data);
                    check_eq("beat_last", 32'(last_o), 32'(e.last));
                    check_eq("beat_stall", 32'(stall_o), 32'd1);
                    if (e.last) begin
                        check_eq("beat_count", 32'(beats), 32'(NREGS + 2));
                        beats = 0;
                    end
                end
            end
            hold      = valid_o && !ready_i;
            hold_data = data_o;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1);
    end

    initial begin
        int drop_before;
        rst_i     = 1'b0;
        enable_i  = 1'b1;
        trigger_i = 1'b0;
        ready_i   = 1'b1;
        pc_i      = 32'h0;
        for (int k = 0; k < int'(NREGS); k++) rf[k] = 32'(k * 3);
        #12;
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_data", data_o, 32'd0);
        check_eq("rst_drop", 32'(drop_cnt_o), 32'd0);
        check_eq("rst_addr", 32'(rf_addr_o), 32'd0);
        tick();
        rst_i = 1'b1;
        tick();

        // Full-rate frame, then a back-pressured frame with identical content
        run_frame(0, 32'h0000_0040);
        run_frame(1, 32'h0000_0040);

        // Triggers while busy: three drops, then saturation
        ready_i   = 1'b0;
        pc_i      = 32'h0000_0080;
        trigger_i = 1'b1;
        push_frame(32'h0000_0080);
        tick();
        pc_i = 32'h1234_5678;
        repeat (3) tick();
        trigger_i = 1'b0;
        @(negedge clk_i);
        check_eq("drop_three", 32'(drop_cnt_o), 32'd3);
        tick();
        trigger_i = 1'b1;
        repeat (300) tick();
        trigger_i = 1'b0;
        @(negedge clk_i);
        check_eq("drop_sat", 32'(drop_cnt_o), 32'd255);
        tick();
        ready_i = 1'b1;
        wait_idle("drop_frame_done");
        repeat (5) tick();
        check_eq("drop_single_frame", 32'(valid_o), 32'd0);
        check_eq("drop_queue", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a frame
        pc_i      = 32'h0000_0100;
        trigger_i = 1'b1;
        push_frame(32'h0000_0100);
        tick();
        trigger_i = 1'b0;
        repeat (10) tick();
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("mid_rst_valid", 32'(valid_o), 32'd0);
        check_eq("mid_rst_busy", 32'(busy_o), 32'd0);
        check_eq("mid_rst_stall", 32'(stall_o), 32'd0);
        check_eq("mid_rst_last", 32'(last_o), 32'd0);
        check_eq("mid_rst_data", data_o, 32'd0);
        check_eq("mid_rst_drop", 32'(drop_cnt_o), 32'd0);
        check_eq("mid_rst_addr", 32'(rf_addr_o), 32'd0);
        exp_q.delete();
        exp_seq = 0;
        tick();
        rst_i = 1'b1;
        repeat (3) tick();
        check_eq("post_rst_idle", 32'(valid_o), 32'd0);
        run_frame(0, 32'h0000_0040);

        // Disabled trigger is ignored entirely
        drop_before = int'(drop_cnt_o);
        enable_i    = 1'b0;
        trigger_i   = 1'b1;
        tick();
        trigger_i   = 1'b0;
        tick();
        @(negedge clk_i);
        check_eq("dis_busy", 32'(busy_o), 32'd0);
        check_eq("dis_stall", 32'(stall_o), 32'd0);
        check_eq("dis_valid", 32'(valid_o), 32'd0);
        check_eq("dis_drop", 32'(drop_cnt_o), 32'(drop_before));
        enable_i = 1'b1;
        tick();

        // Sequence wrap with a 2-bit counter, fresh register contents each frame
        for (int f = 1; f <= 4; f++) begin
            for (int k = 0; k < int'(NREGS); k++) rf[k] = 32'(k * 7 + f * 32'h1000);
            run_frame(0, 32'(32'h200 + f * 4));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_state_streamer.md
Name: cpu_state_streamer

Overview:
- Hardware counterpart to the bench-side register/PC dump of the single-cycle CPU.
- On a trigger, freezes the CPU via stall_o and serialises a snapshot as one valid/ready frame:
  - a header beat,
  - a PC beat,
  - one beat per architectural register, read through a dedicated register-file read port.
- Sits beside CPU, PC and Registers; drives a debug/trace sink such as a UART bridge or trace FIFO.

Parameters:
- NUM_REGS, 32, number of registers streamed (x0..x[NUM_REGS-1]); 1..32.
- MAGIC, 8'hA5, value in header bits [31:24].
- SEQ_W, 16, width of the frame sequence counter; 1..24.

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- rst_i, input, 1, asynchronous active-low reset.
- enable_i, input, 1, when low, triggers are ignored and not counted.
- trigger_i, input, 1, snapshot request, sampled on the rising edge.
- pc_i, input, 32, CPU PC register output.
- rf_addr_o, output, 5, register-file debug read address.
- rf_data_i, input, 32, combinational read data for rf_addr_o.
- stall_o, output, 1, freezes PC and register writes while high.
- data_o, output, 32, stream beat data.
- valid_o, output, 1, beat valid.
- ready_i, input, 1, sink ready.
- last_o, output, 1, final beat of frame.
- busy_o, output, 1, frame in progress.
- drop_cnt_o, output, 8, triggers lost while busy; saturates at 255.

Behaviour:
- Reset (rst_i low, asynchronous) forces every output to 0:
  - state IDLE, sequence counter 0, beat counter 0, drop_cnt_o 0.
  - Reset mid-frame aborts the frame immediately; no partial-frame completion after release.
- States: IDLE, HDR, PCB, REGS.
  - IDLE -> HDR at edge E when trigger_i & enable_i. At E:
    - capture pc_i into the PC holding register;
    - load data_o = {MAGIC, 8'h00 padded to width, seq}, with seq zero-extended into bits [23:0];
    - set valid_o, busy_o and stall_o (all registered);
    - beat counter = 0.
  - HDR -> PCB on handshake (valid_o & ready_i). data_o = captured PC.
  - PCB -> REGS on handshake. data_o = rf_data_i with rf_addr_o = 0; index = 1.
  - In REGS, each handshake with index < NUM_REGS:
    - data_o = rf_data_i at rf_addr_o = index;
    - index increments.
  - last_o = 1 while the beat for register NUM_REGS-1 is presented.
  - Handshake on the last beat -> IDLE:
    - valid_o, last_o, busy_o and stall_o cleared at that edge;
    - seq increments, wrapping 2^SEQ_W-1 -> 0.
  - NUM_REGS=1: the x0 beat carries last_o.
- rf_addr_o = index of the next register to be loaded; it is 0 in IDLE, HDR and PCB.
- Beat data is registered and held stable while valid_o & !ready_i. valid_o never drops without a handshake, except on reset.
- With ready_i held high, a frame is exactly NUM_REGS+2 consecutive valid cycles starting the cycle after E; trigger-to-first-beat latency is 1 cycle.
- Snapshot consistency:
  - The captured PC belongs to the instruction whose writeback occurred at E.
  - stall_o is high from just after E, so register contents read during the frame equal the state after E.
  - The CPU must not write registers while stall_o is high.
- Trigger in the last-beat handshake cycle: the frame ends, the trigger counts as a drop, and no back-to-back start. A new frame starts only from IDLE.
- trigger_i & enable_i while busy: drop_cnt_o increments, saturating at 255.
- The frame in progress is unaffected by enable_i changes.

Test Plan:
- Regs xk = k*3, pc_i = 0x40, one trigger, ready_i = 1:
  - 34 beats: 0xA5000000, 0x00000040, then 0, 3, 6, ..., 93;
  - last_o only on beat 33; stall_o high 34 cycles; seq then 1.
- Same frame with ready_i toggling 1,0,0,1:
  - data_o and valid_o stable while ready_i is 0;
  - beat order and values identical to the first scenario; no duplicated or skipped register.
- Three triggers while busy, then 300 triggers while busy:
  - drop_cnt_o = 3 after the first three, then saturates at 255;
  - only one frame is emitted.
- rst_i pulsed low at beat 10:
  - all outputs 0 immediately;
  - next trigger yields header 0xA5000000 (seq restarted) and a full 34-beat frame.
- SEQ_W=2, five frames: headers carry seq 0, 1, 2, 3, 0.
- enable_i = 0 with a trigger pulse: stays IDLE, drop_cnt_o unchanged, stall_o remains 0.
